// File: rtl/flag_branch_sequencer.sv
// Instruction-cycle controller: fetch/decode/execute sequencing,
// flag write strobing and hazard-free conditional jump resolution.
module flag_branch_sequencer #(
  parameter int OPC_W       = 3,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPC_W-1:0] opc,
  input  logic [2:0]       cond,
  input  logic             alu_done,
  input  logic             fl,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             s_al,
  output logic [2:0]       oc_fl,
  output logic             branch_taken,
  output logic             halted,
  output logic             err,
  output logic [3:0]       state_o
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_AWAIT  = 4'd2,
    S_FLWR   = 4'd3,
    S_SETTLE = 4'd4,
    S_COND   = 4'd5,
    S_HALT   = 4'd6,
    S_ERR    = 4'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      oc_fl_q, oc_fl_d;
  logic            pend_q, pend_d;

  logic is_nop, is_alu, is_jmp, is_jcc, is_hlt;
  logic cnt_last;

  assign is_nop = (opc == OPC_W'(0));
  assign is_alu = (opc == OPC_W'(1));
  assign is_jmp = (opc == OPC_W'(2));
  assign is_jcc = (opc == OPC_W'(3));
  assign is_hlt = (opc == OPC_W'(4));

  assign cnt_last = (cnt_q == CW'(ALU_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      oc_fl_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oc_fl_q <= oc_fl_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oc_fl_d = oc_fl_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_nop: begin
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end
          is_alu: begin
            pend_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_AWAIT;
          end
          is_jmp: begin
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end
          is_jcc: begin
            oc_fl_d = cond;
            state_d = pend_q ? S_SETTLE : S_COND;
          end
          is_hlt: begin
            pend_d  = 1'b0;
            state_d = S_HALT;
          end
          default: state_d = S_ERR;
        endcase
      end
      S_AWAIT: begin
        // done on the limit cycle still wins over the timeout
        if (alu_done) begin
          state_d = S_FLWR;
        end else if (cnt_last) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLWR: begin
        pend_d  = 1'b1;
        state_d = S_FETCH;
      end
      S_SETTLE: begin
        pend_d  = 1'b0;
        state_d = S_COND;
      end
      S_COND:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    s_al         = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_load = instr_valid;
        pc_inc  = instr_valid;
      end
      S_DECODE: begin
        pc_load      = is_jmp;
        branch_taken = is_jmp;
      end
      S_FLWR: s_al = 1'b1;
      S_COND: begin
        pc_load      = fl;
        branch_taken = fl;
      end
      S_HALT: halted = 1'b1;
      S_ERR:  err    = 1'b1;
      default: ;
    endcase
  end

  assign oc_fl   = oc_fl_q;
  assign state_o = state_q;

endmodule

// File: doc/flag_branch_sequencer.md
Name: flag_branch_sequencer

Overview:
Instruction-cycle controller for the RNBIP-2 core. It sequences fetch/decode/execute, strobes the flag register write (s_al) after ALU operations, and drives the 3-bit flag select (oc_fl). It samples the selected flag (fl) to resolve conditional jumps. It guarantees a conditional jump never reads a flag that is still being written.

Parameters:
OPC_W, 3, width of the opcode-class field from IR
ALU_TIMEOUT, 15, max cycles to wait for alu_done before entering ERR (must be >=1)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  IR holds a fetched instruction
opc  in  OPC_W  opcode class: 0 NOP, 1 ALU, 2 JMP, 3 JCC, 4 HALT, others illegal
cond  in  3  condition code from IR, 0 Z, 1 NZ, 2 C, 3 NC, 4 P, 5 N, 6 PO, 7 PE
alu_done  in  1  ALU result stable, one-cycle pulse
fl  in  1  selected flag from flag register
ir_load  out  1  load IR, one-cycle pulse
pc_inc  out  1  PC+1, one-cycle pulse
pc_load  out  1  PC<=target, one-cycle pulse
s_al  out  1  flag register write enable, one-cycle pulse
oc_fl  out  3  flag select to flag register (registered)
branch_taken  out  1  pulse with pc_load on a resolved jump
halted  out  1  level, core stopped
err  out  1  level, illegal opcode or ALU timeout
state_o  out  4  current state encoding, debug

Behaviour:
- Reset (async, rst_n=0): state=FETCH, all pulses 0, oc_fl=0, halted=0, err=0, timeout counter=0, flag_pending=0. Reset in any state aborts immediately. No partial pulse may be seen after release.
- States: FETCH(0), DECODE(1), ALU_WAIT(2), FLAG_WR(3), FLAG_SETTLE(4), COND(5), HALT(6), ERR(7).
- FETCH: wait for instr_valid=1, then assert ir_load and pc_inc for 1 cycle and go to DECODE.
- DECODE:
  - NOP -> FETCH.
  - ALU -> ALU_WAIT, counter cleared.
  - JMP -> assert pc_load and branch_taken, then FETCH.
  - JCC -> oc_fl<=cond, then COND. If flag_pending=1, go to FLAG_SETTLE first.
  - HALT -> HALT.
  - Illegal -> ERR.
- ALU_WAIT: each cycle without alu_done increments the counter. alu_done=1 -> FLAG_WR. If the counter reaches ALU_TIMEOUT with no alu_done -> ERR. alu_done on the same cycle the counter hits the limit counts as done.
- FLAG_WR: s_al=1 for exactly one cycle, flag_pending<=1, then FETCH.
- FLAG_SETTLE: one bubble cycle so the flag register output reflects the last write. Clear flag_pending, then COND.
- COND: sample fl.
  - fl=1 -> pc_load=1 and branch_taken=1 for 1 cycle.
  - fl=0 -> no PC action.
  - Next state is FETCH either way.
- flag_pending is set in FLAG_WR and cleared in FLAG_SETTLE, or in DECODE of any non-JCC opcode, because the flags are stable by then.
- Latencies:
  - NOP: 2 cycles.
  - JMP: 2 cycles.
  - JCC: 3 cycles, or 4 when it directly follows an ALU instruction.
  - ALU: 3 + wait cycles.
- HALT/ERR are terminal; only reset exits. halted=1 in HALT, err=1 in ERR. All pulses stay 0 in both.
- Mutual exclusion: pc_inc and pc_load are never high in the same cycle. s_al is never high in the same cycle as pc_load.
- oc_fl holds its value outside JCC. It changes only in DECODE for JCC.
- instr_valid is ignored outside FETCH.

Test Plan:
- Reset mid-ALU_WAIT (rst_n low for 1 cycle): all outputs 0, state_o=0. The next instr_valid yields ir_load one cycle later.
- ALU (alu_done on 2nd wait cycle), then JCC cond=0 with fl=1 after settle: s_al pulses once, FLAG_SETTLE is visited (state_o=4), oc_fl=0, and pc_load=branch_taken=1 in COND.
- JCC cond=3 preceded by a NOP with fl=0: no FLAG_SETTLE, oc_fl=3, no pc_load, back in FETCH 3 cycles after ir_load.
- JMP: pc_load=branch_taken=1 exactly the cycle after ir_load. pc_inc=0 in that cycle.
- ALU with alu_done never asserted (ALU_TIMEOUT=15): err=1 after 15 wait cycles, s_al never pulses, and further instr_valid is ignored.
- opc=5 -> err=1. opc=4 -> halted=1, and both hold until rst_n=0.
